// File: rtl/mem_useq_if.sv
// mem_useq_if: request/acknowledge and control-word bundle between a sequencer user and mem_useq
interface mem_useq_if #(parameter int CTRL_W = 8);
    logic [1:0] en;
    logic [7:0] instr;
    logic start;
    logic mem_rdy;
    logic [CTRL_W-1:0] ctrl;
    logic mem_req;
    logic mem_we;
    logic busy;
    logic done;
    logic err;
    modport master (output en, instr, start, mem_rdy, input ctrl, mem_req, mem_we, busy, done, err);
    modport slave (input en, instr, start, mem_rdy, output ctrl, mem_req, mem_we, busy, done, err);
endinterface

// File: rtl/mem_useq.sv
// mem_useq: four-state memory access micro-sequencer with table-driven control word, wait timeout and abort
module mem_useq #(
    parameter int CTRL_W = 8,
    parameter int TIMEOUT = 15,
    parameter int BUS_HOLD = 0
) (
    input logic clk,
    input logic rst,
    mem_useq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, XFER} state_t;
    state_t state, nstate;
    logic [1:0] op, nop, hold, nhold;
    logic dir, ndir, err_n, done_n, act_n;
    logic [7:0] cnt, ncnt, val;
    logic unused_bits;
    assign unused_bits = ^{bus.instr[7], bus.instr[3:0]};
    function automatic logic [7:0] tbl(input logic [1:0] o, input logic d);
        return o == 2'd0 ? 8'h00 : o == 2'd1 ? (d ? 8'h06 : 8'h04) :
               o == 2'd2 ? (d ? 8'h07 : 8'h05) : (d ? 8'h70 : 8'h0F);
    endfunction
    // next state, latched instruction and counters; outputs are derived from the next state so they register cleanly
    always_comb begin
        nstate = state;
        nop = op;
        ndir = dir;
        ncnt = cnt;
        nhold = hold;
        err_n = 1'b0;
        if (state != IDLE && bus.en != 2'b11)
            nstate = IDLE;
        else
            case (state)
                IDLE: if (bus.start && bus.en == 2'b11) begin
                    nop = bus.instr[6:5];
                    ndir = bus.instr[4];
                    nstate = (bus.instr[6:5] == 2'd0 || (bus.instr[6:5] == 2'd3 && !bus.instr[4])) ? XFER : ADDR;
                    ncnt = 8'd0;
                    nhold = 2'd0;
                end
                ADDR: nstate = WAIT;
                WAIT: if (bus.mem_rdy) begin
                    nstate = XFER;
                    nhold = 2'd0;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    nstate = IDLE;
                    err_n = 1'b1;
                end else
                    ncnt = cnt + 8'd1;
                XFER: if (hold == 2'(BUS_HOLD))
                    nstate = IDLE;
                else
                    nhold = hold + 2'd1;
            endcase
        act_n = nstate == ADDR || nstate == WAIT;
        done_n = nstate == XFER && nhold == 2'(BUS_HOLD);
        val = tbl(nop, ndir);
    end
    // state and registered outputs; write ops drive ctrl from ADDR onward, reads only in XFER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op <= 2'd0;
            dir <= 1'b0;
            cnt <= 8'd0;
            hold <= 2'd0;
            bus.ctrl <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            state <= nstate;
            op <= nop;
            dir <= ndir;
            cnt <= ncnt;
            hold <= nhold;
            bus.ctrl <= (nstate == XFER || (act_n && ndir)) ? CTRL_W'(val) : '0;
            bus.mem_req <= act_n;
            bus.mem_we <= act_n && ndir;
            bus.busy <= nstate != IDLE;
            bus.done <= done_n;
            bus.err <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_useq.sv
// tb_mem_useq: table vectors, hand-written corner sequences and randomized ops against a transaction-level model
module tb_mem_useq;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int asrt = 0;
    int fails = 0;
    mem_useq_if #(8) b0();
    mem_useq_if #(8) b2();
    assign b2.en = b0.en;
    assign b2.instr = b0.instr;
    assign b2.start = b0.start;
    assign b2.mem_rdy = b0.mem_rdy;
    mem_useq #(.CTRL_W(8), .TIMEOUT(TO), .BUS_HOLD(0)) dut (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_useq #(.CTRL_W(8), .TIMEOUT(TO), .BUS_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    always #5 clk = ~clk;
    logic [12:0] o0, o2;
    assign o0 = {b0.ctrl, b0.mem_req, b0.mem_we, b0.busy, b0.done, b0.err};
    assign o2 = {b2.ctrl, b2.mem_req, b2.mem_we, b2.busy, b2.done, b2.err};
    typedef struct {
        logic [7:0] instr;
        int k;
        logic [7:0] ctrl;
        logic [7:0] pre;
        logic we;
        int req;
        int done;
        int err;
    } vec_t;
    vec_t vt[10];
    logic [12:0] exp_q[$];
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        asrt++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask
    function automatic void build(input logic [7:0] ins, input int k);
        logic [7:0] rtab[4] = '{8'h00, 8'h04, 8'h05, 8'h0F};
        logic [7:0] wtab[4] = '{8'h00, 8'h06, 8'h07, 8'h70};
        logic [1:0] op = ins[6:5];
        logic d = ins[4];
        logic [7:0] v = d ? wtab[op] : rtab[op];
        exp_q.delete();
        if (!(op == 2'd0 || (op == 2'd3 && !d))) begin
            int nw = k < TO ? k + 1 : TO;
            for (int i = 0; i < 1 + nw; i++) exp_q.push_back({d ? v : 8'h00, 1'b1, d, 1'b1, 1'b0, 1'b0});
            if (k >= TO) begin
                exp_q.push_back({8'h00, 5'b00001});
                return;
            end
        end
        exp_q.push_back({v, 5'b00110});
        exp_q.push_back(13'd0);
    endfunction
    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] c = 0, pre = 0;
        logic we = 0;
        int req = 0, dn = 0, er = 0;
        logic fin = 0;
        @(negedge clk);
        b0.start = 1; b0.instr = v.instr; b0.mem_rdy = 0;
        for (int e = 1; e <= 40 && !fin; e++) begin
            @(negedge clk);
            if (b0.done) begin dn++; c = b0.ctrl; end
            er += int'(b0.err);
            req += int'(b0.mem_req);
            if (b0.mem_req) pre |= b0.ctrl;
            we |= b0.mem_we;
            fin = !b0.busy;
            b0.start = 0;
            b0.mem_rdy = (e == 2 + v.k);
        end
        b0.mem_rdy = 0;
        check($sformatf("vec%0d_finish", idx), fin, 1);
        check($sformatf("vec%0d_ctrl", idx), c, v.ctrl);
        check($sformatf("vec%0d_pre_ctrl", idx), pre, v.pre);
        check($sformatf("vec%0d_we", idx), we, v.we);
        check($sformatf("vec%0d_req_cycles", idx), req, v.req);
        check($sformatf("vec%0d_done", idx), dn, v.done);
        check($sformatf("vec%0d_err", idx), er, v.err);
    endtask
    task automatic rand_op(input logic [7:0] ins, input int k);
        logic sh = ins[6:5] == 2'd0 || (ins[6:5] == 2'd3 && !ins[4]);
        build(ins, k);
        @(negedge clk);
        b0.start = 1; b0.instr = ins; b0.mem_rdy = 0;
        for (int e = 1; e <= exp_q.size(); e++) begin
            @(negedge clk);
            check($sformatf("rand instr=%h k=%0d cyc%0d", ins, k, e), o0, exp_q[e-1]);
            b0.start = (e < exp_q.size() && exp_q[e-1][2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            b0.instr = 8'($urandom);
            b0.mem_rdy = (e == 2 + k) || ((sh || e == 1 || e > 2 + k) && $urandom_range(0, 1) == 1);
        end
        b0.start = 0; b0.mem_rdy = 0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{8'h20, 0, 8'h04, 8'h00, 1'b0, 2, 1, 0};
        vt[1] = '{8'h70, 3, 8'h70, 8'h70, 1'b1, 5, 1, 0};
        vt[2] = '{8'h60, 0, 8'h0F, 8'h00, 1'b0, 0, 1, 0};
        vt[3] = '{8'h00, 0, 8'h00, 8'h00, 1'b0, 0, 1, 0};
        vt[4] = '{8'h10, 0, 8'h00, 8'h00, 1'b0, 0, 1, 0};
        vt[5] = '{8'h40, 1, 8'h05, 8'h00, 1'b0, 3, 1, 0};
        vt[6] = '{8'h50, 14, 8'h07, 8'h07, 1'b1, 16, 1, 0};
        vt[7] = '{8'h30, 15, 8'h00, 8'h06, 1'b1, 16, 0, 1};
        vt[8] = '{8'hA0, 2, 8'h04, 8'h00, 1'b0, 4, 1, 0};
        vt[9] = '{8'h2F, 0, 8'h04, 8'h00, 1'b0, 2, 1, 0};
        b0.en = 2'b11; b0.instr = 8'h00; b0.start = 0; b0.mem_rdy = 0;
        @(negedge clk);
        check("reset_outputs", o0, 0);
        check("reset_outputs_bh2", o2, 0);
        rst = 0;
        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);
        // start while busy ignored, then back-to-back start honoured in the IDLE cycle after done
        @(negedge clk);
        b0.start = 1; b0.instr = 8'h60;
        @(negedge clk);
        check("b2b_clear_done", {b0.ctrl, b0.done, b0.mem_req}, {8'h0F, 2'b10});
        b0.instr = 8'h20;
        @(negedge clk);
        check("busy_start_ignored", {b0.busy, b0.done}, 2'b00);
        @(negedge clk);
        check("b2b_addr", {b0.busy, b0.mem_req, b0.ctrl}, {2'b11, 8'h00});
        b0.start = 0;
        @(negedge clk);
        b0.mem_rdy = 1;
        @(negedge clk);
        check("b2b_read_done", {b0.ctrl, b0.done}, {8'h04, 1'b1});
        b0.mem_rdy = 0;
        // abort in WAIT with mem_rdy in the same cycle
        @(negedge clk);
        b0.start = 1; b0.instr = 8'h70;
        @(negedge clk);
        b0.start = 0;
        @(negedge clk);
        check("abort_pre_wait", {b0.mem_req, b0.mem_we, b0.ctrl}, {2'b11, 8'h70});
        b0.en = 2'b00; b0.mem_rdy = 1;
        @(negedge clk);
        check("abort_idle", o0, 0);
        b0.en = 2'b11; b0.mem_rdy = 0;
        // BUS_HOLD = 2 gives three XFER cycles with done only in the last
        @(negedge clk);
        b0.start = 1; b0.instr = 8'h00;
        @(negedge clk);
        b0.start = 0;
        check("bh2_c1", {b2.busy, b2.done}, 2'b10);
        @(negedge clk);
        check("bh2_c2", {b2.busy, b2.done}, 2'b10);
        @(negedge clk);
        check("bh2_c3", {b2.busy, b2.done}, 2'b11);
        @(negedge clk);
        check("bh2_c4", {b2.busy, b2.done}, 2'b00);
        // async reset in XFER, then a start right after release
        @(negedge clk);
        b0.start = 1; b0.instr = 8'h60;
        @(negedge clk);
        b0.start = 0;
        check("rst_pre_xfer", {b2.busy, b2.ctrl}, {1'b1, 8'h0F});
        #2 rst = 1;
        #1 check("rst_async", o2, 0);
        @(negedge clk);
        check("rst_no_done", o2, 0);
        rst = 0; b0.start = 1; b0.instr = 8'h60;
        @(posedge clk);
        #1 check("rst_first_start", {b0.done, b0.ctrl}, {1'b1, 8'h0F});
        @(negedge clk);
        b0.start = 0;
        repeat (3) @(negedge clk);
        for (int n = 0; n < 60; n++) rand_op(8'($urandom), int'($urandom_range(0, 17)));
        $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
        $finish;
    end
endmodule

// File: doc/mem_useq.md
MEM_USEQ -- requirements
Module: mem_useq

Interface
REQ-001 Parameter CTRL_W, default 8, control word width (CTRL_W >= 8).
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-003 Parameter BUS_HOLD, default 0, extra XFER hold cycles after the first XFER cycle (0..3).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  2  operation enable; the block is enabled only when en == 2'b11.
REQ-007 instr  input  8  instruction; [6:5] = op, [4] = direction (0 read, 1 write); other bits ignored.
REQ-008 start  input  1  request strobe, sampled only in IDLE.
REQ-009 mem_rdy  input  1  memory acknowledge, sampled only in WAIT.
REQ-010 ctrl  output  CTRL_W  control word; table value zero-extended to CTRL_W.
REQ-011 mem_req  output  1  memory access request.
REQ-012 mem_we  output  1  memory write qualifier, valid while mem_req = 1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one pulse per completed operation.
REQ-015 err  output  1  one-cycle pulse on timeout.

Function
REQ-016 Control table, read (dir 0): op 00 -> 0x00, 01 -> 0x04, 10 -> 0x05, 11 -> 0x0F.
REQ-017 Control table, write (dir 1): op 00 -> 0x00, 01 -> 0x06, 10 -> 0x07, 11 -> 0x70.
REQ-018 The FSM states are IDLE, ADDR, WAIT and XFER; all outputs are registered.
REQ-019 IDLE: on start = 1 with en == 2'b11, latch instr[6:4] and go to the next state selected by REQ-020; otherwise stay in IDLE.
REQ-020 Next state from IDLE: op 00 (NOP, either direction) -> XFER; read op 11 (CLEAR) -> XFER; all other ops -> ADDR.
REQ-021 ADDR: lasts 1 cycle; mem_req = 1; mem_we = dir; then go to WAIT.
REQ-022 WAIT: mem_req = 1; mem_we = dir; a 8-bit wait counter increments each cycle.
REQ-023 WAIT exit on mem_rdy = 1 -> XFER.
REQ-024 WAIT exit on timeout: the counter reaches TIMEOUT - 1 with mem_rdy = 0 -> IDLE; err = 1 for 1 cycle; done stays 0.
REQ-025 Write ops: ctrl = table value in ADDR, WAIT and XFER, so the bus is driven before and through the acknowledge.
REQ-026 Read ops: ctrl = table value in XFER only; ctrl = 0 in ADDR and WAIT.
REQ-027 XFER: mem_req = 0; lasts 1 + BUS_HOLD cycles; done = 1 in the last XFER cycle; then go to IDLE.
REQ-028 In IDLE, ctrl = 0, mem_req = 0, mem_we = 0, done = 0 and err = 0.
REQ-029 Abort: en != 2'b11 in any non-IDLE state forces IDLE on the next edge, with ctrl = 0, no done and no err.
REQ-030 start while busy = 1 is ignored and not queued.
REQ-031 The latched instr is used for the whole operation; instr changes while busy have no effect.
REQ-032 The wait counter clears on every entry to ADDR.
REQ-033 Abort has priority over mem_rdy when both occur in the same WAIT cycle.
REQ-034 mem_rdy takes priority over timeout when both occur in the same WAIT cycle.
REQ-035 A start sampled in the IDLE cycle following done or err begins a new operation (back-to-back allowed).

Reset
REQ-036 rst = 1 immediately forces state = IDLE and all outputs and counters to 0, independent of clk.
REQ-037 Reset asserted mid-operation discards the operation; no done or err is produced.
REQ-038 After rst deasserts, the first start is honoured on the first rising edge.

Verification
REQ-039 Read A: en = 11, instr = 0x20, start; mem_rdy high in the 1st WAIT cycle -> ADDR, WAIT, XFER, with ctrl = 0x04 and done = 1 in the XFER cycle (edge 3).
REQ-040 Write R: instr = 0x70, mem_rdy after 3 WAIT cycles -> mem_we = 1 and ctrl = 0x70 from ADDR through XFER; one done pulse.
REQ-041 CLEAR and NOP: instr = 0x60 -> XFER at edge 1 with ctrl = 0x0F and done = 1, and no mem_req; instr = 0x00 -> ctrl = 0x00 and done = 1.
REQ-042 Timeout: TIMEOUT = 15 with mem_rdy held low -> err pulse after the 15th WAIT cycle, done = 0, and the block returns to IDLE.
REQ-043 Abort and reset: en dropped to 00 in WAIT -> IDLE next edge, ctrl = 0; rst pulsed in XFER -> outputs 0 at once, with no done.
REQ-044 Edge cases: start while busy is ignored; BUS_HOLD = 2 gives 3 XFER cycles with done only in the last; back-to-back start right after done completes.
